pixel_word_packer: RTL and testbench

//  Packs native video pixels (de/idata) into AXI-width words for the write path ahead of mm_tras FIFO.

---
 rtl/pixel_word_packer_pkg.sv | 14 +
 rtl/pixel_word_packer_if.sv | 13 +
 rtl/pack_out_fifo.sv | 44 ++++
 rtl/pixel_word_packer.sv | 172 +++++++++++++++++
 tb/tb_pixel_word_packer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_word_packer_pkg.sv
// Shared types and sizing helpers for the pixel word packer.
// Word tags travel alongside packed data through the output buffer.
package pixel_pack_pkg;

   typedef struct packed {
      logic last;
      logic user;
   } pack_tag_t;

   function automatic int pix_per_word(input int dsize, input int axi_dsize);
      return axi_dsize / dsize;
   endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Output word stream of the pixel word packer (valid/ready with line/frame tags).
interface pixel_word_packer_if #(
   parameter int AXI_DSIZE = 256
);
   logic [AXI_DSIZE-1:0] odata;
   logic                 ovalid;
   logic                 oready;
   logic                 olast;
   logic                 ouser;

   modport master (output odata, ovalid, olast, ouser, input oready);
   modport slave  (input odata, ovalid, olast, ouser, output oready);
endinterface

// File: rtl/pack_out_fifo.sv
// Two-entry synchronous FIFO; reset empties it, output reads zero while empty.
module pack_out_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= !wr_ptr_q;
         if (do_pop)  rd_ptr_q <= !rd_ptr_q;
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   // NOTE: storage has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs DSIZE pixels into AXI_DSIZE words tagged with first-of-frame and last-of-line.
// Optional statistics ports are built when PIXEL_PACKER_STAT_EN is defined.
module pixel_word_packer
   import pixel_pack_pkg::*;
#(
   parameter int DSIZE     = 24,
   parameter int AXI_DSIZE = 256
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [15:0]           hactive,
   input  logic                  vsync,
   input  logic                  de,
   input  logic [DSIZE-1:0]      idata,
   pixel_word_packer_if.master   out_if,
   output logic                  overflow,
   output logic                  err_short,
   output logic                  err_long
`ifdef PIXEL_PACKER_STAT_EN
   ,
   output logic [31:0]           frame_words,
   output logic [15:0]           line_count
`endif
);
   localparam int PPW    = pix_per_word(DSIZE, AXI_DSIZE);
   localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int FIFO_W = AXI_DSIZE + $bits(pack_tag_t);

   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [15:0]          pix_q, pix_d;
   logic [15:0]          hact_q, hact_d;
   logic [AXI_DSIZE-1:0] acc_q, acc_d;
   logic                 sof_q, sof_d;
   logic                 de_q;
   logic                 overflow_q, overflow_d;
   logic                 err_short_q, err_short_d;
   logic                 err_long_q, err_long_d;

   logic                 push;
   logic [AXI_DSIZE-1:0] push_word;
   pack_tag_t            push_tag;
   logic [AXI_DSIZE-1:0] merged;
   logic                 line_end;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FIFO_W-1:0]    fifo_dout;
   pack_tag_t            out_tag;

   assign merged   = acc_q | (AXI_DSIZE'(idata) << (int'(lane_q) * DSIZE));
   assign line_end = (pix_q == hact_q - 16'd1);
   assign pop      = out_if.ovalid && out_if.oready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      lane_d      = lane_q;
      pix_d       = pix_q;
      hact_d      = hact_q;
      acc_d       = acc_q;
      sof_d       = sof_q;
      overflow_d  = overflow_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      push        = 1'b0;
      push_word   = acc_q;
      push_tag    = '0;

      if (vsync) begin
         lane_d = '0;
         pix_d  = '0;
         acc_d  = '0;
         hact_d = hactive;
         sof_d  = 1'b1;
      end else if (de) begin
         if (pix_q < hact_q) begin
            // Line end leaves pix at hactive: the line stays closed until de falls.
            pix_d = pix_q + 16'd1;
            if (lane_q == LANE_W'(PPW - 1) || line_end) begin
               push          = 1'b1;
               push_word     = merged;
               push_tag.last = line_end;
               lane_d        = '0;
               acc_d         = '0;
            end else begin
               lane_d = lane_q + LANE_W'(1);
               acc_d  = merged;
            end
         end else begin
            err_long_d = 1'b1;
         end
      end else if (de_q) begin
         if (pix_q != 16'd0 && pix_q < hact_q) begin
            push          = 1'b1;
            push_word     = acc_q;
            push_tag.last = 1'b1;
            err_short_d   = 1'b1;
         end
         lane_d = '0;
         pix_d  = '0;
         acc_d  = '0;
      end

      if (push) begin
         push_tag.user = sof_q;
         sof_d         = 1'b0;
         if (fifo_full && !pop) overflow_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (rst) begin
         lane_q      <= '0;
         pix_q       <= '0;
         hact_q      <= hactive;
         acc_q       <= '0;
         sof_q       <= 1'b1;
         de_q        <= 1'b0;
         overflow_q  <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         pix_q       <= pix_d;
         hact_q      <= hact_d;
         acc_q       <= acc_d;
         sof_q       <= sof_d;
         de_q        <= de;
         overflow_q  <= overflow_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
      end
   end

   pack_out_fifo #(.WIDTH(FIFO_W)) u_out_fifo (
      .clock   (clock),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({push_word, push_tag}),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign {out_if.odata, out_tag} = fifo_dout;
   assign out_if.ovalid = !fifo_empty;
   assign out_if.olast  = out_tag.last;
   assign out_if.ouser  = out_tag.user;
   assign overflow      = overflow_q;
   assign err_short     = err_short_q;
   assign err_long      = err_long_q;

`ifdef PIXEL_PACKER_STAT_EN
   logic [31:0] frame_words_q;
   logic [15:0] line_count_q;

   always_ff @(posedge clock) begin
      if (rst || vsync) begin
         frame_words_q <= '0;
         line_count_q  <= '0;
      end else if (push) begin
         frame_words_q <= frame_words_q + 32'd1;
         if (push_tag.last) line_count_q <= line_count_q + 16'd1;
      end
   end

   assign frame_words = frame_words_q;
   assign line_count  = line_count_q;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: a line-level model predicts words, a monitor checks them.
module tb_pixel_word_packer;
   localparam int DSIZE     = 24;
   localparam int AXI_DSIZE = 256;
   localparam int PPW       = AXI_DSIZE / DSIZE;

   typedef struct {
      logic [AXI_DSIZE-1:0] data;
      logic                 last;
      logic                 user;
   } exp_t;

   logic             clock;
   logic             rst;
   logic [15:0]      hactive;
   logic             vsync;
   logic             de;
   logic [DSIZE-1:0] idata;
   logic             overflow;
   logic             err_short;
   logic             err_long;

   pixel_word_packer_if #(.AXI_DSIZE(AXI_DSIZE)) pif ();

   pixel_word_packer #(.DSIZE(DSIZE), .AXI_DSIZE(AXI_DSIZE)) dut (
      .clock     (clock),
      .rst       (rst),
      .hactive   (hactive),
      .vsync     (vsync),
      .de        (de),
      .idata     (idata),
      .out_if    (pif),
      .overflow  (overflow),
      .err_short (err_short),
      .err_long  (err_long)
   );

   exp_t             exp_q[$];
   logic [DSIZE-1:0] pix_buf[$];
   bit               exp_sof;
   bit               rand_ready;
   int               n_checks;
   int               n_errors;
   exp_t             mon_e;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [AXI_DSIZE-1:0] act,
                        input logic [AXI_DSIZE-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (rand_ready) pif.oready = ($urandom_range(0, 7) != 0);
   endtask

   // Line-level reference: accepted pixels = min(de count, hactive); full lines split
   // into ceil(h/PPW) words, short lines emit completed words plus one flushed remainder.
   task automatic expect_line(input int h);
      int   n;
      int   acc;
      int   nwords;
      exp_t e;
      n      = pix_buf.size();
      acc    = (n < h) ? n : h;
      nwords = (n >= h) ? (acc + PPW - 1) / PPW : acc / PPW + 1;
      for (int w = 0; w < nwords; w++) begin
         e.data = '0;
         for (int k = 0; k < PPW; k++) begin
            if (w * PPW + k < acc) e.data[k*DSIZE +: DSIZE] = pix_buf[w*PPW + k];
         end
         e.last  = (w == nwords - 1);
         e.user  = exp_sof;
         exp_sof = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic run_line(input int h, input int n, input bit ramp);
      pix_buf.delete();
      for (int i = 0; i < n; i++)
         pix_buf.push_back(ramp ? DSIZE'(i) : DSIZE'($urandom));
      expect_line(h);
      for (int i = 0; i < n; i++) begin
         de    = 1'b1;
         idata = pix_buf[i];
         step();
      end
      de    = 1'b0;
      idata = '0;
      step();
   endtask

   task automatic do_vsync(input int h);
      hactive = 16'(h);
      vsync   = 1'b1;
      step();
      vsync   = 1'b0;
      exp_sof = 1'b1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      de    = 1'b0;
      vsync = 1'b0;
      step();
      step();
      rst   = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         step();
         cyc++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   always @(negedge clock) begin
      if (!rst && pif.ovalid && pif.oready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_word: got odata %0h with nothing expected", pif.odata);
         end else begin
            mon_e = exp_q.pop_front();
            check("odata", pif.odata, mon_e.data);
            check("olast", pif.olast, mon_e.last);
            check("ouser", pif.ouser, mon_e.user);
         end
      end
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rand_ready = 1'b0;
      exp_sof    = 1'b0;
      hactive    = 16'd25;
      vsync      = 1'b0;
      de         = 1'b0;
      idata      = '0;
      pif.oready = 1'b1;
      rst        = 1'b1;
      step();
      do_reset();

      check("rst_ovalid", pif.ovalid, 0);
      check("rst_olast", pif.olast, 0);
      check("rst_ouser", pif.ouser, 0);
      check("rst_odata", pif.odata, 0);
      check("rst_overflow", overflow, 0);
      check("rst_err_short", err_short, 0);
      check("rst_err_long", err_long, 0);

      // 25-pixel ramp: two full words and a 5-lane tail.
      do_vsync(25);
      run_line(25, 25, 1'b1);
      wait_drain("h25");
      check("h25_err_short", err_short, 0);
      check("h25_err_long", err_long, 0);

      // 1920-pixel line: 192 full words, only the first tagged ouser.
      do_vsync(1920);
      run_line(1920, 1920, 1'b0);
      wait_drain("h1920");
      run_line(1920, 1920, 1'b0);
      wait_drain("h1920_line2");
      check("h1920_overflow", overflow, 0);

      // Short line: de falls after 7 of 20 pixels.
      do_vsync(20);
      run_line(20, 7, 1'b1);
      wait_drain("short");
      check("short_err_short", err_short, 1);
      check("short_err_long", err_long, 0);
      do_reset();
      check("short_rst_clear", err_short, 0);

      // Long line with vsync coinciding with de: that pixel is dropped.
      hactive = 16'd10;
      vsync   = 1'b1;
      de      = 1'b1;
      idata   = 24'hABCDEF;
      step();
      vsync   = 1'b0;
      exp_sof = 1'b1;
      run_line(10, 12, 1'b0);
      wait_drain("long");
      check("long_err_long", err_long, 1);
      check("long_err_short", err_short, 0);
      do_reset();

      // Stalled consumer: third word of a 30-pixel line is lost.
      do_vsync(30);
      pif.oready = 1'b0;
      run_line(30, 30, 1'b0);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      check("ovf_overflow", overflow, 1);
      check("ovf_ovalid", pif.ovalid, 1);
      pif.oready = 1'b1;
      wait_drain("ovf");
      do_reset();
      check("ovf_rst_clear", overflow, 0);

      // Reset mid-line with one word buffered.
      do_vsync(30);
      pif.oready = 1'b0;
      for (int i = 0; i < 13; i++) begin
         de    = 1'b1;
         idata = DSIZE'($urandom);
         step();
      end
      check("midrst_buffered", pif.ovalid, 1);
      rst   = 1'b1;
      de    = 1'b0;
      step();
      check("midrst_ovalid", pif.ovalid, 0);
      rst        = 1'b0;
      pif.oready = 1'b1;
      do_vsync(5);
      run_line(5, 5, 1'b1);
      wait_drain("midrst");

      // Randomized frames with random line lengths and back-pressure.
      do_reset();
      rand_ready = 1'b1;
      for (int f = 0; f < 5; f++) begin
         int h;
         h = $urandom_range(1, 35);
         do_vsync(h);
         for (int l = 0; l < 4; l++) begin
            run_line(h, $urandom_range(1, h + 3), 1'b0);
            for (int g = $urandom_range(1, 4); g > 0; g--) step();
         end
      end
      wait_drain("random");
      check("random_overflow", overflow, 0);
      rand_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
